mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter sharing the multicycle MIPS's single unified instruction/data memory between the CPU core and a debug/loader port. Each requester uses a level-held request with a one-cycle acknowledge. The arbiter grants round-robin, latches the winning request and drives the memory through a ready handshake. The core keeps `pcen`/`irwrite` gated off until `cpu_ack`, so fetches and loads see stall cycles transparently.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 15, XFER cycles with `mem_ready` low before abort (≥1; used only with `MEMARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU request, held until `cpu_ack`
- `cpu_we`  in  1  CPU write (1) / read (0)
- `cpu_adr`  in  AW  CPU byte address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_rdata`  out  DW  CPU read data, registered
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_err`  out  1  completion was a timeout abort (pulses with ack)
- `dbg_req`, `dbg_we`, `dbg_adr`, `dbg_wdata`, `dbg_rdata`, `dbg_ack`, `dbg_err`  same as the CPU signals, for the debug port
- `mem_en`  out  1  memory access active
- `mem_we`  out  1  memory write strobe
- `mem_adr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid when `mem_ready`=1
- `mem_ready`  in  1  memory completes the access this cycle; may be combinational on `mem_en`

## Operation
- States: IDLE, XFER, ACK. Registers: `gnt` (0=CPU, 1=DBG), `last`, latched `we`/`adr`/`wdata`.
- IDLE:
  - No request: stay in IDLE.
  - Only one requester asserting: grant it.
  - Both asserting: grant the port not equal to `last`.
  - On grant: latch that port's `we`/`adr`/`wdata`, set `gnt` and `last`, go to XFER.
- XFER:
  - `mem_en`=1; `mem_we`/`mem_adr`/`mem_wdata` come from the latched registers.
  - On `mem_ready`=1: if read, register `mem_rdata` into the granted port's `rdata`; go to ACK.
- ACK: the granted port's `ack`=1 for exactly this cycle; `mem_en`=0; go to IDLE.
- `rdata` holds its value until that port's next completed read; writes leave it unchanged.
- The requester must drop `req` in the cycle after `ack`. IDLE samples `req` again one cycle after ACK, so there is no double grant.
- A requester dropping `req` mid-transfer is a protocol violation. The latched transfer completes and `ack` is still issued.
- `mem_we` is never asserted while `mem_en`=0.
- Reset (asserted any time, including mid-XFER):
  - State → IDLE, `last` → DBG, so the CPU wins the first tie.
  - All outputs 0 immediately; `rdata` registers 0.
  - The aborted transfer is never acked.

## Timing
- Zero-wait memory: `req` seen in IDLE at cycle N → XFER (`mem_en`) at N+1 → `ack` at N+2 → IDLE at N+3.
- Peak rate: one transfer per 3 cycles.
- Each wait cycle (`mem_ready` low in XFER) adds one cycle.
- `rdata` is valid in the same cycle `ack` is high and stays valid afterwards.
- Under continuous contention, grants alternate CPU, DBG, CPU, …; worst-case wait for either port is one foreign transfer.

## Configuration
- `MEMARB_TIMEOUT_EN` defined:
  - A counter clears on XFER entry and increments each XFER cycle with `mem_ready`=0.
  - When `mem_ready` is still 0 in the TIMEOUT-th XFER cycle, XFER ends and the next cycle is ACK.
  - In that ACK cycle the granted port's `err`=1 alongside `ack`; a read abort loads `rdata`=32'hDEADBEEF.
  - `mem_ready` arriving in the TIMEOUT-th cycle is a normal completion.
- Not defined:
  - No counter; XFER waits indefinitely for `mem_ready`.
  - `cpu_err`/`dbg_err` tied 0.

## Test plan
- Reset low mid-XFER: all outputs 0 at once. After release, CPU read of 0x40 with zero-wait memory returning 0x12345678 gives `cpu_ack` 2 cycles after request seen and `cpu_rdata`=0x12345678.
- CPU and DBG request in the same cycle after reset: CPU granted first, then DBG. DBG write to 0x100 of 0xCAFEF00D appears on `mem_*` with `mem_we`=1; `dbg_rdata` unchanged.
- Both hold requests for 6 transfers: grant order is C,D,C,D,C,D, and each ack is exactly 1 cycle wide.
- `mem_ready` delayed 4 cycles on a CPU read: `cpu_ack` arrives 4 cycles later than zero-wait; `mem_adr` is stable throughout XFER.
- `MEMARB_TIMEOUT_EN`, TIMEOUT=15, `mem_ready` stuck 0: after 15 XFER cycles, `cpu_ack`=`cpu_err`=1 and `cpu_rdata`=0xDEADBEEF. Without the macro, no ack after 100 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin CPU/debug arbiter for the shared MIPS memory
// Optional MEMARB_TIMEOUT_EN aborts transfers stalled TIMEOUT cycles and flags err with ack.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_err,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_adr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic          dbg_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    state_t        state_q;
    logic          gnt_q;
    logic          last_q;
    logic          we_q;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dbg_rdata_q;
    logic          pick_dbg;

    // On a tie the port that did not win last time goes next.
    assign pick_dbg = dbg_req && (!cpu_req || (last_q == PORT_CPU));

`ifdef MEMARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            gnt_q       <= PORT_CPU;
            last_q      <= PORT_DBG;
            we_q        <= 1'b0;
            adr_q       <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
`ifdef MEMARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req || dbg_req) begin
                        gnt_q   <= pick_dbg;
                        last_q  <= pick_dbg;
                        we_q    <= pick_dbg ? dbg_we    : cpu_we;
                        adr_q   <= pick_dbg ? dbg_adr   : cpu_adr;
                        wdata_q <= pick_dbg ? dbg_wdata : cpu_wdata;
                        state_q <= XFER;
`ifdef MEMARB_TIMEOUT_EN
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
`endif
                    end
                end
                XFER: begin
                    if (mem_ready) begin
                        if (!we_q) begin
                            if (gnt_q == PORT_DBG) dbg_rdata_q <= mem_rdata;
                            else                   cpu_rdata_q <= mem_rdata;
                        end
                        state_q <= ACK;
                    end
`ifdef MEMARB_TIMEOUT_EN
                    // cnt_q counts earlier stalled cycles, so TIMEOUT-1 marks the last allowed one.
                    else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        if (!we_q) begin
                            if (gnt_q == PORT_DBG) dbg_rdata_q <= DW'(32'hDEADBEEF);
                            else                   cpu_rdata_q <= DW'(32'hDEADBEEF);
                        end
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_en    = (state_q == XFER);
    assign mem_we    = mem_en && we_q;
    assign mem_adr   = adr_q;
    assign mem_wdata = wdata_q;

    assign cpu_ack   = (state_q == ACK) && (gnt_q == PORT_CPU);
    assign dbg_ack   = (state_q == ACK) && (gnt_q == PORT_DBG);
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

`ifdef MEMARB_TIMEOUT_EN
    assign cpu_err   = cpu_ack && err_q;
    assign dbg_err   = dbg_ack && err_q;
`else
    assign cpu_err   = 1'b0;
    assign dbg_err   = 1'b0;
`endif

endmodule
